// File: rtl/mips_pkg.sv
// Shared types for the MIPS memory-region controller: region descriptor, default map, FSM states.
package mips_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_WAIT_W = 4;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] base;
    logic [MEM_ADDR_W-1:0] limit;
    logic [MEM_WAIT_W-1:0] wait_cycles;
    logic                  top_rel;
    logic [MEM_ADDR_W-1:0] top_offset;
  } mem_region_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } mem_ctrl_state_e;

  localparam mem_region_t MEM_RGN_TEXT = '{
    base: 32'h0040_0000, limit: 32'h004F_FFFF, wait_cycles: 4'd0,
    top_rel: 1'b0, top_offset: 32'h0000_0000};
  localparam mem_region_t MEM_RGN_DATA = '{
    base: 32'h1001_0000, limit: 32'h1001_FFFF, wait_cycles: 4'd1,
    top_rel: 1'b0, top_offset: 32'h0000_0000};
  // Stack grows down: offsets are measured back from the top word.
  localparam mem_region_t MEM_RGN_STACK = '{
    base: 32'h7FFE_F000, limit: 32'h7FFF_EFFC, wait_cycles: 4'd0,
    top_rel: 1'b1, top_offset: 32'h0000_FFFC};
  localparam mem_region_t MEM_RGN_MMIO = '{
    base: 32'hFFFF_0000, limit: 32'hFFFF_FFFF, wait_cycles: 4'd2,
    top_rel: 1'b0, top_offset: 32'h0000_0000};

  // Index 0 is the least-significant element.
  localparam mem_region_t [3:0] MEM_REGION_MAP_DEFAULT =
    {MEM_RGN_MMIO, MEM_RGN_STACK, MEM_RGN_DATA, MEM_RGN_TEXT};

endpackage

// File: rtl/mips_mem_region_dec.sv
// Combinational region decoder: lowest-index hit wins, produces one-hot hit and local offset.
module mips_mem_region_dec
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter mem_region_t [NUM_REGIONS-1:0] REGION_MAP = MEM_REGION_MAP_DEFAULT
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] hit_c,
  output logic [ADDR_W-1:0]      offset_c
);

  logic found;

  always_comb begin
    hit_c    = '0;
    offset_c = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found &&
          addr >= ADDR_W'(REGION_MAP[i].base) &&
          addr <= ADDR_W'(REGION_MAP[i].limit)) begin
        found    = 1'b1;
        hit_c[i] = 1'b1;
        if (REGION_MAP[i].top_rel)
          offset_c = addr - ADDR_W'(REGION_MAP[i].limit) + ADDR_W'(REGION_MAP[i].top_offset);
        else
          offset_c = addr - ADDR_W'(REGION_MAP[i].base);
      end
    end
  end

endmodule

// File: rtl/mips_mem_region_ctrl.sv
// Sequential data-bus region controller: one request in flight, per-region wait states.
// Optional fault log enabled by defining MEM_CTRL_ERR_LOG_EN.
module mips_mem_region_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_W      = 4,
  parameter mem_region_t [NUM_REGIONS-1:0] REGION_MAP = MEM_REGION_MAP_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_val,
  output logic                          req_rdy,
  input  logic                          req_wr,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          rsp_val,
  input  logic                          rsp_rdy,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_REGIONS-1:0]        rgn_sel,
  output logic                          rgn_rd,
  output logic                          rgn_wr,
  output logic [ADDR_W-1:0]             rgn_addr,
  output logic [DATA_W-1:0]             rgn_wdata,
`ifdef MEM_CTRL_ERR_LOG_EN
  input  logic                          err_clr,
  output logic [ADDR_W-1:0]             err_addr,
  output logic                          err_wr,
  output logic [7:0]                    err_cnt,
`endif
  input  logic [NUM_REGIONS*DATA_W-1:0] rgn_rdata
);

  mem_ctrl_state_e         state_q, state_d;
  logic [WAIT_W-1:0]       wcnt_q, wcnt_d;
  logic                    wr_q, wr_d;
  logic                    req_rdy_q, req_rdy_d;
  logic                    rsp_val_q, rsp_val_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REGIONS-1:0]  rgn_sel_q, rgn_sel_d;
  logic                    rgn_rd_q, rgn_rd_d;
  logic                    rgn_wr_q, rgn_wr_d;
  logic [ADDR_W-1:0]       rgn_addr_q, rgn_addr_d;
  logic [DATA_W-1:0]       rgn_wdata_q, rgn_wdata_d;

  logic [NUM_REGIONS-1:0]  dec_hit_c;
  logic [ADDR_W-1:0]       dec_offset_c;
  logic [WAIT_W-1:0]       hit_wait_c;
  logic [DATA_W-1:0]       sel_rdata_c;
  logic                    accept_c;

  mips_mem_region_dec #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_MAP  (REGION_MAP)
  ) u_dec (
    .addr     (req_addr),
    .hit_c    (dec_hit_c),
    .offset_c (dec_offset_c)
  );

  assign accept_c = req_val & req_rdy_q;

  // Wait count of the hit region and read data of the held region (both one-hot muxes).
  always_comb begin
    hit_wait_c  = '0;
    sel_rdata_c = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (dec_hit_c[i]) hit_wait_c  = hit_wait_c | WAIT_W'(REGION_MAP[i].wait_cycles);
      if (rgn_sel_q[i]) sel_rdata_c = sel_rdata_c | rgn_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      wr_q        <= 1'b0;
      req_rdy_q   <= 1'b1;
      rsp_val_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rgn_sel_q   <= '0;
      rgn_rd_q    <= 1'b0;
      rgn_wr_q    <= 1'b0;
      rgn_addr_q  <= '0;
      rgn_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wr_q        <= wr_d;
      req_rdy_q   <= req_rdy_d;
      rsp_val_q   <= rsp_val_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rgn_sel_q   <= rgn_sel_d;
      rgn_rd_q    <= rgn_rd_d;
      rgn_wr_q    <= rgn_wr_d;
      rgn_addr_q  <= rgn_addr_d;
      rgn_wdata_q <= rgn_wdata_d;
    end
  end

  // Outputs are computed for the state being entered so that every port is a flop.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    wr_d        = wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rgn_sel_d   = rgn_sel_q;
    rgn_addr_d  = rgn_addr_q;
    rgn_wdata_d = rgn_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          wr_d        = req_wr;
          rsp_rdata_d = '0;
          if (|dec_hit_c) begin
            state_d     = ST_ACCESS;
            wcnt_d      = hit_wait_c;
            rgn_sel_d   = dec_hit_c;
            rgn_addr_d  = dec_offset_c;
            rgn_wdata_d = req_wdata;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end else begin
          state_d     = ST_RESP;
          rsp_rdata_d = wr_q ? '0 : sel_rdata_c;
          rgn_sel_d   = '0;
          rgn_addr_d  = '0;
          rgn_wdata_d = '0;
        end
      end
      ST_RESP, ST_ERR: begin
        if (rsp_rdy) begin
          state_d     = ST_IDLE;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_rdy_d = (state_d == ST_IDLE);
    rsp_val_d = (state_d == ST_RESP) || (state_d == ST_ERR);
    rsp_err_d = (state_d == ST_ERR);
    rgn_rd_d  = (state_d == ST_ACCESS) && (wcnt_d == '0) && !wr_d;
    rgn_wr_d  = (state_d == ST_ACCESS) && (wcnt_d == '0) && wr_d;
  end

  assign req_rdy   = req_rdy_q;
  assign rsp_val   = rsp_val_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rgn_sel   = rgn_sel_q;
  assign rgn_rd    = rgn_rd_q;
  assign rgn_wr    = rgn_wr_q;
  assign rgn_addr  = rgn_addr_q;
  assign rgn_wdata = rgn_wdata_q;

`ifdef MEM_CTRL_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              err_wr_q, err_wr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_entry_c;

  assign err_entry_c = (state_q == ST_IDLE) && (state_d == ST_ERR);

  // Sticky first-fault capture with saturating count; clear beats a coincident fault.
  always_comb begin
    err_addr_d = err_addr_q;
    err_wr_d   = err_wr_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      err_addr_d = '0;
      err_wr_d   = 1'b0;
      err_cnt_d  = '0;
    end else if (err_entry_c) begin
      if (err_cnt_q == 8'd0) begin
        err_addr_d = req_addr;
        err_wr_d   = req_wr;
      end
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q <= '0;
      err_wr_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_wr_q   <= err_wr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_wr   = err_wr_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_mips_mem_region_ctrl.sv
// Directed bench for mips_mem_region_ctrl; fault-log checks compile in with MEM_CTRL_ERR_LOG_EN.
module tb_mips_mem_region_ctrl;

  logic        clk;
  logic        rst;
  logic        req_val, req_rdy, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_val, rsp_rdy, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  rgn_sel;
  logic        rgn_rd, rgn_wr;
  logic [31:0] rgn_addr, rgn_wdata;
  logic [127:0] rgn_rdata;
`ifdef MEM_CTRL_ERR_LOG_EN
  logic        err_clr;
  logic [31:0] err_addr;
  logic        err_wr;
  logic [7:0]  err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  mips_mem_region_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_val   (rsp_val),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rgn_sel   (rgn_sel),
    .rgn_rd    (rgn_rd),
    .rgn_wr    (rgn_wr),
    .rgn_addr  (rgn_addr),
    .rgn_wdata (rgn_wdata),
`ifdef MEM_CTRL_ERR_LOG_EN
    .err_clr   (err_clr),
    .err_addr  (err_addr),
    .err_wr    (err_wr),
    .err_cnt   (err_cnt),
`endif
    .rgn_rdata (rgn_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept in cycle 0, then per-cycle checks through the response handshake.
  task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] exp_sel,
                         input logic [31:0] exp_off, input int wt, input logic miss,
                         input logic [31:0] exp_rd, input int hold, input logic busy_val);
    req_val   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_rdy   = (hold == 0);
    chk({tag, ".req_rdy0"}, 32'(req_rdy), 32'd1);
    tick();
    req_val  = busy_val;
    req_addr = 32'h0000_0020;
    if (!miss) begin
      for (int c = 0; c < wt; c++) begin
        chk({tag, ".wait_sel"}, 32'(rgn_sel), 32'(exp_sel));
        chk({tag, ".wait_strobe"}, 32'({rgn_rd, rgn_wr}), 32'd0);
        chk({tag, ".wait_rdy"}, 32'(req_rdy), 32'd0);
        tick();
      end
      chk({tag, ".sel"}, 32'(rgn_sel), 32'(exp_sel));
      chk({tag, ".addr"}, rgn_addr, exp_off);
      chk({tag, ".rd"}, 32'(rgn_rd), 32'(!wr));
      chk({tag, ".wr"}, 32'(rgn_wr), 32'(wr));
      chk({tag, ".early_val"}, 32'(rsp_val), 32'd0);
      if (wr) chk({tag, ".wdata"}, rgn_wdata, wdata);
      tick();
      chk({tag, ".err"}, 32'(rsp_err), 32'd0);
      chk({tag, ".rdata"}, rsp_rdata, wr ? 32'd0 : exp_rd);
    end else begin
      chk({tag, ".err"}, 32'(rsp_err), 32'd1);
      chk({tag, ".rdata"}, rsp_rdata, 32'd0);
    end
    chk({tag, ".val"}, 32'(rsp_val), 32'd1);
    chk({tag, ".rsp_strobe"}, 32'({rgn_rd, rgn_wr}), 32'd0);
    chk({tag, ".rsp_sel"}, 32'(rgn_sel), 32'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".hold_val"}, 32'(rsp_val), 32'd1);
      chk({tag, ".hold_rdy"}, 32'(req_rdy), 32'd0);
    end
    rsp_rdy = 1'b1;
    req_val = 1'b0;
    tick();
    rsp_rdy = 1'b0;
    chk({tag, ".done_val"}, 32'(rsp_val), 32'd0);
    chk({tag, ".done_rdy"}, 32'(req_rdy), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_val   = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_rdy   = 1'b0;
    rgn_rdata = {32'hCAFE_0003, 32'h2222_5555, 32'h1111_AAAA, 32'hDEAD_BEEF};
`ifdef MEM_CTRL_ERR_LOG_EN
    err_clr   = 1'b0;
`endif
    tick();
    tick();
    chk("reset.req_rdy", 32'(req_rdy), 32'd1);
    chk("reset.rsp_val", 32'(rsp_val), 32'd0);
    chk("reset.sel", 32'(rgn_sel), 32'd0);
    chk("reset.strobe", 32'({rgn_rd, rgn_wr}), 32'd0);
    rst = 1'b0;
    tick();

    run_req("t1_text_rd", 1'b0, 32'h0040_0000, 32'h0, 4'b0001, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    run_req("t2_data_wr", 1'b1, 32'h1001_0008, 32'h1234_5678, 4'b0010, 32'h8, 1, 1'b0, 32'h0, 0, 1'b0);
    run_req("t3_stack_top", 1'b0, 32'h7FFF_EFFC, 32'h0, 4'b0100, 32'h0000_FFFC, 0, 1'b0, 32'h2222_5555, 0, 1'b0);
    run_req("t3_stack_bot", 1'b0, 32'h7FFE_F000, 32'h0, 4'b0100, 32'h0, 0, 1'b0, 32'h2222_5555, 0, 1'b0);
    run_req("text_limit", 1'b0, 32'h004F_FFFF, 32'h0, 4'b0001, 32'h000F_FFFF, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    run_req("mmio_top", 1'b0, 32'hFFFF_FFFF, 32'h0, 4'b1000, 32'h0000_FFFF, 2, 1'b0, 32'hCAFE_0003, 0, 1'b0);

    run_req("t4_miss", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 0, 1'b1, 32'h0, 0, 1'b0);
`ifdef MEM_CTRL_ERR_LOG_EN
    chk("t4.err_addr1", err_addr, 32'h0000_0010);
    chk("t4.err_cnt1", 32'(err_cnt), 32'd1);
    chk("t4.err_wr1", 32'(err_wr), 32'd0);
`endif
    run_req("miss_past_text", 1'b1, 32'h0050_0000, 32'h55, 4'b0000, 32'h0, 0, 1'b1, 32'h0, 0, 1'b0);
    run_req("miss_below_data", 1'b0, 32'h1000_FFFF, 32'h0, 4'b0000, 32'h0, 0, 1'b1, 32'h0, 0, 1'b0);
`ifdef MEM_CTRL_ERR_LOG_EN
    chk("t4.err_addr3", err_addr, 32'h0000_0010);
    chk("t4.err_wr3", 32'(err_wr), 32'd0);
    chk("t4.err_cnt3", 32'(err_cnt), 32'd3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr.err_addr", err_addr, 32'd0);
    chk("clr.err_cnt", 32'(err_cnt), 32'd0);
`endif

    run_req("t5_mmio_hold", 1'b0, 32'hFFFF_0004, 32'h0, 4'b1000, 32'h4, 2, 1'b0, 32'hCAFE_0003, 3, 1'b1);
    tick();
    chk("t5.no_extra_rsp", 32'(rsp_val), 32'd0);

    // Reset lands in the first ACCESS cycle of an MMIO read.
    req_val  = 1'b1;
    req_wr   = 1'b0;
    req_addr = 32'hFFFF_0004;
    rsp_rdy  = 1'b1;
    tick();
    req_val = 1'b0;
    chk("t6.pre_sel", 32'(rgn_sel), 32'b1000);
    rst = 1'b1;
    #1;
    chk("t6.sel", 32'(rgn_sel), 32'd0);
    chk("t6.strobe", 32'({rgn_rd, rgn_wr}), 32'd0);
    chk("t6.req_rdy", 32'(req_rdy), 32'd1);
    chk("t6.rsp_val", 32'(rsp_val), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t6.no_rsp", 32'(rsp_val | rgn_rd), 32'd0);
    end
    rsp_rdy = 1'b0;
    run_req("t6_after", 1'b0, 32'hFFFF_0008, 32'h0, 4'b1000, 32'h8, 2, 1'b0, 32'hCAFE_0003, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
